// File: rtl/hamming_stream_checker.sv
// Streaming Hamming SEC checker/corrector.
// Accepts one received block per cycle, computes its syndrome, optionally
// repairs a single-bit error, and presents the extracted data with error
// status through a single registered output stage. Sticky and saturating
// error statistics are kept alongside for CSR readout.
//
// Block layout: 1-indexed position p lives in block bit p-1. Parity bits sit
// at the power-of-two positions; data bits fill the remaining positions in
// ascending order (data bit 0 at the lowest). Parity bit k covers every
// position whose index has bit k set.
//
// Known limitation: this is a SEC-only code. A double-bit error produces a
// non-zero syndrome that aliases to some single position and gets
// "corrected" into wrong data.

package hamming_stream_checker_pkg;

  // Number of power-of-two positions that fit inside the block.
  function automatic int GET_HAMMING_PARITY_WIDTH_FROM_BLOCK_WIDTH(input int block_width);
    int parity_bits;
    parity_bits = 0;
    while ((1 << parity_bits) <= block_width) begin
      parity_bits = parity_bits + 1;
    end
    return parity_bits;
  endfunction

  function automatic int GET_HAMMING_DATA_WIDTH_FROM_BLOCK_WIDTH(input int block_width);
    return block_width - GET_HAMMING_PARITY_WIDTH_FROM_BLOCK_WIDTH(block_width);
  endfunction

  // 1-indexed block position holding data bit data_index.
  function automatic int hamming_data_position(input int data_index);
    int position;
    int seen;
    position = 0;
    seen     = -1;
    while (seen < data_index) begin
      position = position + 1;
      if ((position & (position - 1)) != 0) begin
        seen = seen + 1;
      end
    end
    return position;
  endfunction

endpackage

module hamming_stream_checker
  import hamming_stream_checker_pkg::*;
#(
  parameter int BLOCK_WIDTH       = 15,
  parameter int CORRECTION_ENABLE = 1,
  parameter int COUNTER_WIDTH     = 16,
  localparam int DATA_WIDTH   = GET_HAMMING_DATA_WIDTH_FROM_BLOCK_WIDTH(BLOCK_WIDTH),
  localparam int PARITY_WIDTH = GET_HAMMING_PARITY_WIDTH_FROM_BLOCK_WIDTH(BLOCK_WIDTH)
) (
  input  logic                     clock,
  input  logic                     reset,
  // Upstream block stream
  input  logic                     upstream_valid,
  output logic                     upstream_ready,
  input  logic [BLOCK_WIDTH-1:0]   upstream_block,
  // Downstream result stream
  output logic                     downstream_valid,
  input  logic                     downstream_ready,
  output logic [DATA_WIDTH-1:0]    downstream_data,
  output logic                     downstream_error,
  output logic                     downstream_corrected,
  output logic                     downstream_uncorrectable,
  output logic [PARITY_WIDTH-1:0]  downstream_syndrome,
  // Statistics
  input  logic                     clear_statistics,
  output logic                     sticky_error,
  output logic [COUNTER_WIDTH-1:0] corrected_count,
  output logic [COUNTER_WIDTH-1:0] uncorrectable_count
);

  // Handshake: a beat moves on a side when valid && ready are both high at
  // the rising clock edge. A producer holds valid and payload stable until
  // the beat moves; ready may depend combinationally on the consumer's ready
  // (upstream_ready = output slot empty or being drained this cycle).

  logic                     upstream_fire;
  logic [PARITY_WIDTH-1:0]  syndrome;
  logic [BLOCK_WIDTH-1:0]   flip_mask;
  logic                     syndrome_nonzero;
  logic                     correct_now;
  logic                     uncorrectable_now;
  logic [BLOCK_WIDTH-1:0]   repaired_block;
  logic [DATA_WIDTH-1:0]    extracted_data;
  logic                     sticky_next;
  logic [COUNTER_WIDTH-1:0] corrected_base;
  logic [COUNTER_WIDTH-1:0] uncorrectable_base;
  logic [COUNTER_WIDTH-1:0] corrected_next;
  logic [COUNTER_WIDTH-1:0] uncorrectable_next;

  assign upstream_ready = !downstream_valid || downstream_ready;
  assign upstream_fire  = upstream_valid && upstream_ready;

  // Syndrome: XOR over every received position covered by each parity bit;
  // including the parity bit itself equals received XOR recomputed parity.
  always_comb begin
    syndrome = '0;
    for (int k = 0; k < PARITY_WIDTH; k++) begin
      for (int p = 1; p <= BLOCK_WIDTH; p++) begin
        if (((p >> k) & 1) == 1) begin
          syndrome[k] = syndrome[k] ^ upstream_block[p-1];
        end
      end
    end
  end

  // One-hot mask of the position the syndrome names; empty when the syndrome
  // is zero or points past the end of a shortened block.
  always_comb begin
    flip_mask = '0;
    for (int p = 1; p <= BLOCK_WIDTH; p++) begin
      if (syndrome == PARITY_WIDTH'(p)) begin
        flip_mask[p-1] = 1'b1;
      end
    end
  end

  assign syndrome_nonzero  = |syndrome;
  assign correct_now       = (CORRECTION_ENABLE != 0) && (|flip_mask);
  assign uncorrectable_now = syndrome_nonzero && !correct_now;
  assign repaired_block    = correct_now ? (upstream_block ^ flip_mask) : upstream_block;

  // Gather the data bits out of the non-power-of-two positions.
  always_comb begin
    extracted_data = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      extracted_data[i] = repaired_block[hamming_data_position(i) - 1];
    end
  end

  // Output register stage: load on an upstream beat, otherwise drop valid
  // once the consumer takes the result; payload holds while stalled.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      downstream_valid         <= 1'b0;
      downstream_data          <= '0;
      downstream_error         <= 1'b0;
      downstream_corrected     <= 1'b0;
      downstream_uncorrectable <= 1'b0;
      downstream_syndrome      <= '0;
    end else if (upstream_fire) begin
      downstream_valid         <= 1'b1;
      downstream_data          <= extracted_data;
      downstream_error         <= syndrome_nonzero;
      downstream_corrected     <= correct_now;
      downstream_uncorrectable <= uncorrectable_now;
      downstream_syndrome      <= syndrome;
    end else if (downstream_ready) begin
      downstream_valid         <= 1'b0;
    end
  end

  // Statistics next-state: a clear wipes the old values first, then any
  // erroneous beat in the same cycle is recorded on top; counters saturate.
  always_comb begin
    sticky_next        = clear_statistics ? 1'b0 : sticky_error;
    corrected_base     = clear_statistics ? '0 : corrected_count;
    uncorrectable_base = clear_statistics ? '0 : uncorrectable_count;
    corrected_next     = corrected_base;
    uncorrectable_next = uncorrectable_base;
    if (upstream_fire) begin
      if (syndrome_nonzero) begin
        sticky_next = 1'b1;
      end
      if (correct_now && (corrected_base != '1)) begin
        corrected_next = corrected_base + COUNTER_WIDTH'(1);
      end
      if (uncorrectable_now && (uncorrectable_base != '1)) begin
        uncorrectable_next = uncorrectable_base + COUNTER_WIDTH'(1);
      end
    end
  end

  // Statistics registers, updated at the upstream transfer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sticky_error        <= 1'b0;
      corrected_count     <= '0;
      uncorrectable_count <= '0;
    end else begin
      sticky_error        <= sticky_next;
      corrected_count     <= corrected_next;
      uncorrectable_count <= uncorrectable_next;
    end
  end

endmodule

// File: tb/tb_hamming_stream_checker.sv
// Bench for hamming_stream_checker. Four instances with different shapes:
//   0: 7-bit block, correcting       1: 7-bit block, detect only
//   2: 6-bit shortened, correcting   3: 15-bit block, 2-bit counters
// Expected results come from a bench-side encoder plus an error-position
// model (syndrome = XOR of the 1-indexed positions that were flipped).
module tb_hamming_stream_checker;

  localparam int W = 23;  // {data[15:0], error, corrected, uncorrectable, syndrome[3:0]}

  function automatic int cfg_bw(input int g);
    case (g)
      0: return 7;
      1: return 7;
      2: return 6;
      default: return 15;
    endcase
  endfunction

  function automatic int cfg_ce(input int g);
    return (g == 1) ? 0 : 1;
  endfunction

  function automatic int cfg_cw(input int g);
    return (g == 3) ? 2 : 16;
  endfunction

  function automatic int par_w(input int bw);
    int p;
    p = 0;
    while ((1 << p) <= bw) p++;
    return p;
  endfunction

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic        up_valid [4];
  logic [15:0] up_block [4];
  logic        dr       [4];
  logic        clr      [4];
  wire         up_ready [4];
  wire         dv       [4];
  wire  [15:0] dd       [4];
  wire         derr     [4];
  wire         dcor     [4];
  wire         dunc     [4];
  wire  [3:0]  dsyn     [4];
  wire         sticky   [4];
  wire  [15:0] ccnt     [4];
  wire  [15:0] ucnt     [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int BW = cfg_bw(g);
    localparam int PW = par_w(BW);
    localparam int DW = BW - PW;
    localparam int CW = cfg_cw(g);
    logic [DW-1:0] d_l;
    logic [PW-1:0] s_l;
    logic [CW-1:0] cc_l;
    logic [CW-1:0] uc_l;
    hamming_stream_checker #(
      .BLOCK_WIDTH(BW),
      .CORRECTION_ENABLE(cfg_ce(g)),
      .COUNTER_WIDTH(CW)
    ) dut (
      .clock(clock),
      .reset(reset),
      .upstream_valid(up_valid[g]),
      .upstream_ready(up_ready[g]),
      .upstream_block(up_block[g][BW-1:0]),
      .downstream_valid(dv[g]),
      .downstream_ready(dr[g]),
      .downstream_data(d_l),
      .downstream_error(derr[g]),
      .downstream_corrected(dcor[g]),
      .downstream_uncorrectable(dunc[g]),
      .downstream_syndrome(s_l),
      .clear_statistics(clr[g]),
      .sticky_error(sticky[g]),
      .corrected_count(cc_l),
      .uncorrectable_count(uc_l)
    );
    assign dd[g]   = 16'(d_l);
    assign dsyn[g] = 4'(s_l);
    assign ccnt[g] = 16'(cc_l);
    assign ucnt[g] = 16'(uc_l);
  end

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int sel     = 0;
  int pops    = 0;
  logic m_st [4];
  int   m_cc [4];
  int   m_uc [4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [15:0] enc(input logic [15:0] data, input int bw);
    logic [15:0] b;
    int j;
    b = '0;
    j = 0;
    for (int p = 1; p <= bw; p++) begin
      if ((p & (p - 1)) != 0) begin
        b[p-1] = data[j];
        j++;
      end
    end
    for (int p = 1; p <= bw; p++) begin
      if ((p & (p - 1)) == 0) begin
        for (int q = 1; q <= bw; q++) begin
          if (q != p && (q & p) != 0) b[p-1] = b[p-1] ^ b[q-1];
        end
      end
    end
    return b;
  endfunction

  function automatic logic [15:0] extract(input logic [15:0] blk, input int bw);
    logic [15:0] d;
    int j;
    d = '0;
    j = 0;
    for (int p = 1; p <= bw; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[j] = blk[p-1];
        j++;
      end
    end
    return d;
  endfunction

  function automatic logic [W-1:0] model(input logic [15:0] data, input logic [15:0] emask, input int g);
    int bw;
    int syn;
    logic cor;
    logic unc;
    logic [15:0] rx;
    bw  = cfg_bw(g);
    syn = 0;
    cor = 1'b0;
    unc = 1'b0;
    rx  = enc(data, bw) ^ emask;
    for (int i = 0; i < bw; i++) if (emask[i]) syn = syn ^ (i + 1);
    if (syn != 0 && cfg_ce(g) != 0 && syn <= bw) begin
      cor = 1'b1;
      rx[syn-1] = ~rx[syn-1];
    end else if (syn != 0) begin
      unc = 1'b1;
    end
    return {extract(rx, bw), (syn != 0), cor, unc, 4'(syn)};
  endfunction

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after the edge that took the beat.
  task automatic drive(input int g, input logic [15:0] blk, input logic [W-1:0] exp);
    int budget;
    logic done_l;
    int sat;
    budget = 0;
    done_l = 1'b0;
    sat = (1 << cfg_cw(g)) - 1;
    up_block[g] = blk;
    up_valid[g] = 1'b1;
    while (!done_l) begin
      @(negedge clock);
      if (up_ready[g]) begin
        if (clr[g]) begin
          m_st[g] = 1'b0;
          m_cc[g] = 0;
          m_uc[g] = 0;
        end
        if (exp[6]) m_st[g] = 1'b1;
        if (exp[5] && m_cc[g] < sat) m_cc[g]++;
        if (exp[4] && m_uc[g] < sat) m_uc[g]++;
        exp_q.push_back(exp);
        done_l = 1'b1;
      end else begin
        budget++;
        if (budget > 100) begin
          check("drive_ready_timeout", 32'(up_ready[g]), 32'd1);
          done_l = 1'b1;
        end
      end
      @(posedge clock);
      #1;
    end
    up_valid[g] = 1'b0;
  endtask

  task automatic send_model(input int g, input logic [15:0] data, input logic [15:0] emask);
    drive(g, enc(data, cfg_bw(g)) ^ emask, model(data, emask, g));
  endtask

  task automatic send_random(input int g);
    int bw;
    int dw;
    logic [15:0] data;
    logic [15:0] emask;
    bw = cfg_bw(g);
    dw = bw - par_w(bw);
    data  = 16'($urandom_range(0, (1 << dw) - 1));
    emask = '0;
    repeat ($urandom_range(0, 2)) emask[$urandom_range(0, bw - 1)] = 1'b1;
    send_model(g, data, emask);
  endtask

  task automatic drain();
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < 100) begin
      @(posedge clock);
      #1;
      b++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_stats(input int g);
    check("sticky", 32'(sticky[g]), 32'(m_st[g]));
    check("corrected_count", 32'(ccnt[g]), 32'(m_cc[g]));
    check("uncorrectable_count", 32'(ucnt[g]), 32'(m_uc[g]));
  endtask

  // ---------------- output monitor ----------------
  // Beats move on the next rising edge when valid && ready at the falling edge.
  always @(negedge clock) begin
    if (!reset && dv[sel] && dr[sel]) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 32'(dv[sel]), 32'd0);
      end else begin
        check("out_pkt", 32'({dd[sel], derr[sel], dcor[sel], dunc[sel], dsyn[sel]}), 32'(exp_q.pop_front()));
        pops++;
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  logic [15:0]  bp_blk [4];
  logic [W-1:0] bp_exp [4];
  logic         rnd_done;
  int           pops_start;

  initial begin
    reset = 1'b1;
    for (int g = 0; g < 4; g++) begin
      up_valid[g] = 1'b0;
      up_block[g] = '0;
      dr[g]       = 1'b1;
      clr[g]      = 1'b0;
      m_st[g]     = 1'b0;
      m_cc[g]     = 0;
      m_uc[g]     = 0;
    end
    repeat (3) @(posedge clock);
    #1;
    for (int g = 0; g < 4; g++) begin
      check("rst_valid", 32'(dv[g]), 32'd0);
      check("rst_ready", 32'(up_ready[g]), 32'd1);
      check("rst_data", 32'(dd[g]), 32'd0);
      chk_stats(g);
    end
    reset = 1'b0;

    // Clean and single-error literal blocks on the 7-bit correcting instance.
    sel = 0;
    drive(0, 16'h0055, {16'hB, 1'b0, 1'b0, 1'b0, 4'd0});
    drain();
    chk_stats(0);
    drive(0, 16'h0045, {16'hB, 1'b1, 1'b1, 1'b0, 4'd5});
    drain();
    check("sticky_after_45", 32'(sticky[0]), 32'd1);
    check("ccnt_after_45", 32'(ccnt[0]), 32'd1);
    chk_stats(0);

    // Detect-only: same corrupted block passes through uncorrected.
    sel = 1;
    drive(1, 16'h0045, {16'h9, 1'b1, 1'b0, 1'b1, 4'd5});
    drain();
    check("ucnt_detect_only", 32'(ucnt[1]), 32'd1);
    chk_stats(1);

    // Shortened code: syndrome 7 points past the 6-bit block.
    sel = 2;
    drive(2, 16'h0026, {16'h5, 1'b1, 1'b0, 1'b1, 4'd7});
    drain();
    send_model(2, 16'h5, 16'h000B);
    drain();
    chk_stats(2);

    // Random blocks with 0..2 flips under random consumer stalls.
    for (int g = 0; g < 4; g++) begin
      sel = g;
      rnd_done = 1'b0;
      fork
        begin
          repeat (25) send_random(g);
          rnd_done = 1'b1;
        end
        begin
          while (!rnd_done) begin
            @(posedge clock);
            #1;
            dr[g] = ($urandom_range(0, 3) != 0);
          end
        end
      join
      dr[g] = 1'b1;
      drain();
      chk_stats(g);
    end

    // Back-pressure: four blocks while the consumer stalls for three cycles.
    sel = 0;
    for (int i = 0; i < 4; i++) begin
      bp_blk[i] = enc(16'(i * 5 + 1), 7) ^ ((i == 2) ? 16'h0008 : 16'h0000);
      bp_exp[i] = model(16'(i * 5 + 1), (i == 2) ? 16'h0008 : 16'h0000, 0);
    end
    pops_start = pops;
    dr[0] = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) drive(0, bp_blk[i], bp_exp[i]);
      end
      begin
        @(posedge clock);
        #1;
        for (int h = 0; h < 3; h++) begin
          @(negedge clock);
          check("bp_upstream_ready", 32'(up_ready[0]), 32'd0);
          check("bp_hold_valid", 32'(dv[0]), 32'd1);
          check("bp_hold_data", 32'(dd[0]), 32'(bp_exp[0][W-1:7]));
        end
        @(posedge clock);
        #1;
        dr[0] = 1'b1;
      end
    join
    drain();
    check("bp_output_count", 32'(pops - pops_start), 32'd4);
    chk_stats(0);

    // Saturation with 2-bit counters, then clear together with a corrected block.
    sel = 3;
    clr[3] = 1'b1;
    @(posedge clock);
    #1;
    clr[3] = 1'b0;
    m_st[3] = 1'b0;
    m_cc[3] = 0;
    m_uc[3] = 0;
    chk_stats(3);
    for (int i = 0; i < 5; i++) send_model(3, 16'($urandom_range(0, 2047)), 16'(1 << $urandom_range(0, 14)));
    drain();
    check("ccnt_saturated", 32'(ccnt[3]), 32'd3);
    chk_stats(3);
    clr[3] = 1'b1;
    send_model(3, 16'h2A5, 16'h0100);
    clr[3] = 1'b0;
    drain();
    check("ccnt_after_clear", 32'(ccnt[3]), 32'd1);
    check("sticky_after_clear", 32'(sticky[3]), 32'd1);
    chk_stats(3);

    // Asynchronous reset while a result is pending.
    sel = 0;
    dr[0] = 1'b0;
    send_model(0, 16'h6, 16'h0004);
    check("pre_reset_valid", 32'(dv[0]), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    check("areset_valid", 32'(dv[0]), 32'd0);
    check("areset_ready", 32'(up_ready[0]), 32'd1);
    check("areset_ccnt", 32'(ccnt[0]), 32'd0);
    check("areset_ucnt", 32'(ucnt[0]), 32'd0);
    check("areset_sticky", 32'(sticky[0]), 32'd0);
    exp_q.delete();
    for (int g = 0; g < 4; g++) begin
      m_st[g] = 1'b0;
      m_cc[g] = 0;
      m_uc[g] = 0;
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    dr[0] = 1'b1;
    send_model(0, 16'h9, 16'h0001);
    drain();
    chk_stats(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hamming_stream_checker.md
Name: hamming_stream_checker

Overview:
- Streaming Hamming checker/corrector for one block per cycle on a valid/ready stream.
- Computes the syndrome of each received block and optionally corrects single-bit errors.
- Registers the extracted data with error status, and keeps sticky and counted error statistics for CSR readout.
- Sits between a memory or link read path and its consumer.

Parameters:
- BLOCK_WIDTH, 15, total Hamming block width in bits. Must be ≥3. Shortened codes are allowed.
- DATA_WIDTH, derived, data bits per block, via GET_HAMMING_DATA_WIDTH_FROM_BLOCK_WIDTH (localparam).
- PARITY_WIDTH, derived, parity bits per block, via GET_HAMMING_PARITY_WIDTH_FROM_BLOCK_WIDTH (localparam).
- CORRECTION_ENABLE, 1, 1 = correct single-bit errors, 0 = detect only.
- COUNTER_WIDTH, 16, width of the saturating error counters.

Ports:
- clock  input  1  clock
- reset  input  1  asynchronous active-high reset
- upstream_valid  input  1  upstream block valid
- upstream_ready  output  1  checker can accept a block
- upstream_block  input  BLOCK_WIDTH  received Hamming block
- downstream_valid  output  1  result valid
- downstream_ready  input  1  consumer accepts result
- downstream_data  output  DATA_WIDTH  extracted data, corrected if applicable
- downstream_error  output  1  syndrome non-zero
- downstream_corrected  output  1  error was corrected
- downstream_uncorrectable  output  1  error present and not corrected
- downstream_syndrome  output  PARITY_WIDTH  raw syndrome
- clear_statistics  input  1  synchronous clear of sticky flag and counters
- sticky_error  output  1  set on any accepted erroneous block
- corrected_count  output  COUNTER_WIDTH  saturating count of corrected blocks
- uncorrectable_count  output  COUNTER_WIDTH  saturating count of uncorrectable blocks

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high. All outputs listed below reset to 0, and upstream_ready is 1 after reset.
- Block layout: 1-indexed position p maps to bit p-1.
  - Parity bits sit at positions 2^k.
  - Data bits fill the remaining positions in ascending order, with data bit 0 at the lowest.
  - Parity bit k covers every position with bit k set.
- Syndrome = received parity XOR parity recomputed from the extracted data. A non-zero syndrome gives the 1-indexed error position.
- Correction (CORRECTION_ENABLE=1):
  - If 1 ≤ syndrome ≤ BLOCK_WIDTH: flip block bit syndrome-1, then extract data. corrected=1.
  - A flipped parity bit gives unchanged data but still counts as corrected.
  - If syndrome > BLOCK_WIDTH (shortened code): no flip, uncorrectable=1.
- Detect only (CORRECTION_ENABLE=0): any non-zero syndrome gives uncorrectable=1 and corrected=0. Data is passed through uncorrected.
- Double-bit errors alias to a wrong single-bit correction. This is accepted and documented as a SEC-only limitation.
- Pipeline: single output register stage.
  - upstream_ready = !downstream_valid || downstream_ready (combinational, no bubble).
  - Transfer on upstream_valid && upstream_ready. Result appears on the next cycle with downstream_valid=1.
  - Latency 1 cycle, throughput 1 block/cycle.
  - downstream_valid falls when downstream_ready is high and no new transfer occurs.
  - Output payload holds stable while downstream_valid && !downstream_ready.
- Statistics: updated at the upstream transfer cycle, not at the output transfer.
  - sticky_error sets on any error.
  - corrected_count increments on corrected; uncorrectable_count increments on uncorrectable.
  - Both counters saturate at 2^COUNTER_WIDTH-1 with no wrap.
- clear_statistics with a same-cycle erroneous transfer: clear applies first, then that event is recorded. The result is sticky_error=1 and the relevant count=1.
- Reset mid-stream: any in-flight result is discarded and statistics are zeroed.

Test Plan:
- BLOCK_WIDTH=7, clean block 7'h55 with downstream_ready=1 -> next cycle: valid=1, data=4'hB, error=0, syndrome=0, counters unchanged.
- BLOCK_WIDTH=7, block 7'h45 (bit 4 flipped) -> data=4'hB, syndrome=5, corrected=1, sticky_error=1, corrected_count=1. With CORRECTION_ENABLE=0 -> data=4'h9, uncorrectable=1, uncorrectable_count=1.
- BLOCK_WIDTH=6 (shortened, DATA_WIDTH=3), block whose bits 0, 1 and 3 are all flipped from a valid codeword (syndrome 7) -> uncorrectable=1, data uncorrected.
- Back-pressure: stream 4 blocks while downstream_ready is held 0 for 3 cycles -> upstream_ready=0 during the hold, first result stable, no loss or duplication, order preserved, full rate after release.
- COUNTER_WIDTH=2: 5 corrected blocks -> corrected_count saturates at 3. Then clear_statistics together with one corrected block -> corrected_count=1 and sticky_error=1.
- Assert reset with downstream_valid=1 -> downstream_valid=0, counters=0, and upstream_ready=1 immediately (asynchronously).
